// File: rtl/mbe_mult_pipe.sv
// Pipelined radix-4 Modified Booth multiplier with valid/ready handshakes on both sides.
// Optional performance counters (perf_txn, perf_stall) are enabled by defining MBE_PERF_CNT_EN.
module mbe_mult_pipe #(
  parameter int WA  = 8,
  parameter int WB  = 8,
  parameter int LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WA-1:0]    in_a,
  input  logic [WB-1:0]    in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WA+WB-1:0] out_prod,
  output logic             out_signed
`ifdef MBE_PERF_CNT_EN
  ,
  output logic [31:0]      perf_txn,
  output logic [31:0]      perf_stall
`endif
);

  localparam int P   = WA + WB;
  localparam int NPP = (WB + 3) / 2;
  localparam int BW  = 2 * NPP;

  logic         adv;
  logic [P-1:0] a_ext;
  logic [P-1:0] a_neg;
  logic [BW-1:0] b_ext;
  logic [BW:0]  b_sh;
  logic [P-1:0] pp_gen [NPP];
  logic [P-1:0] acc0;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // All arithmetic is done modulo 2^P; sign-extended partial products make that exact.
  always_comb begin
    a_ext = {{WB{in_signed & in_a[WA-1]}}, in_a};
    a_neg = ~a_ext + 1'b1;
    b_ext = {{(BW-WB){in_signed & in_b[WB-1]}}, in_b};
    b_sh  = {b_ext, 1'b0};
    for (int i = 0; i < NPP; i++) begin
      pp_gen[i] = '0;
      case (b_sh[2*i+2 -: 3])
        3'b001, 3'b010: pp_gen[i] = a_ext << (2*i);
        3'b011:         pp_gen[i] = a_ext << (2*i+1);
        3'b100:         pp_gen[i] = a_neg << (2*i+1);
        3'b101, 3'b110: pp_gen[i] = a_neg << (2*i);
        default:        pp_gen[i] = '0;
      endcase
    end
  end

  // Stage j sums partial products [j*NPP/LAT, (j+1)*NPP/LAT) into the running total.
  always_comb begin
    acc0 = '0;
    for (int k = 0; k < NPP; k++) begin
      if (k < NPP / LAT) acc0 = acc0 + pp_gen[k];
    end
  end

  if (LAT == 1) begin : g_single
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        out_valid  <= 1'b0;
        out_prod   <= '0;
        out_signed <= 1'b0;
      end else if (adv) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_prod   <= acc0;
          out_signed <= in_signed;
        end
      end
    end
  end else begin : g_multi
    logic [LAT-2:0] vld_q;
    logic [LAT-2:0] sgn_q;
    logic [P-1:0]   acc_q [LAT-1];
    logic [P-1:0]   pp_q  [LAT-1][NPP];
    logic [P-1:0]   acc_d [LAT-1];

    always_comb begin
      for (int j = 1; j < LAT; j++) begin
        acc_d[j-1] = acc_q[j-1];
        for (int k = 0; k < NPP; k++) begin
          if (k >= (j * NPP) / LAT && k < ((j + 1) * NPP) / LAT)
            acc_d[j-1] = acc_d[j-1] + pp_q[j-1][k];
        end
      end
    end

    // Data registers only load behind a valid entry, so bubbles never disturb held results.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q      <= '0;
        sgn_q      <= '0;
        out_valid  <= 1'b0;
        out_prod   <= '0;
        out_signed <= 1'b0;
        for (int j = 0; j < LAT-1; j++) begin
          acc_q[j] <= '0;
          for (int k = 0; k < NPP; k++) pp_q[j][k] <= '0;
        end
      end else if (adv) begin
        vld_q[0] <= in_valid;
        if (in_valid) begin
          acc_q[0] <= acc0;
          sgn_q[0] <= in_signed;
          for (int k = 0; k < NPP; k++) pp_q[0][k] <= pp_gen[k];
        end
        for (int j = 1; j < LAT-1; j++) begin
          vld_q[j] <= vld_q[j-1];
          if (vld_q[j-1]) begin
            acc_q[j] <= acc_d[j-1];
            sgn_q[j] <= sgn_q[j-1];
            for (int k = 0; k < NPP; k++) pp_q[j][k] <= pp_q[j-1][k];
          end
        end
        out_valid <= vld_q[LAT-2];
        if (vld_q[LAT-2]) begin
          out_prod   <= acc_d[LAT-2];
          out_signed <= sgn_q[LAT-2];
        end
      end
    end
  end

`ifdef MBE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_txn   <= '0;
      perf_stall <= '0;
    end else begin
      if (out_valid && out_ready)  perf_txn   <= perf_txn + 32'd1;
      if (out_valid && !out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mbe_mult_pipe.sv
// Scoreboard bench for mbe_mult_pipe: an 8x8 LAT=3 instance plus 5x11 instances at LAT=1 and LAT=8.
module tb_mbe_mult_pipe;
  localparam int WA  = 8;
  localparam int WB  = 8;
  localparam int LAT = 3;

  typedef struct {
    logic [15:0] prod;
    logic        sgn;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_prod;

  logic [1:0]        sw_valid, sw_iready, sw_signed, sw_ov, sw_os;
  logic              sw_oready;
  logic [1:0][4:0]   sw_a;
  logic [1:0][10:0]  sw_b;
  logic [1:0][15:0]  sw_prod;

`ifdef MBE_PERF_CNT_EN
  logic [31:0]       perf_txn, perf_stall;
  logic [1:0][31:0]  sw_ptxn, sw_pstall;
  logic [31:0]       stall_base;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   pops  = 0;
  bit   check_lat = 1'b1;

  always #5 clk = ~clk;

  mbe_mult_pipe #(.WA(WA), .WB(WB), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_signed(out_signed)
`ifdef MBE_PERF_CNT_EN
    , .perf_txn(perf_txn), .perf_stall(perf_stall)
`endif
  );

  mbe_mult_pipe #(.WA(5), .WB(11), .LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[0]), .in_ready(sw_iready[0]),
    .in_a(sw_a[0]), .in_b(sw_b[0]), .in_signed(sw_signed[0]),
    .out_valid(sw_ov[0]), .out_ready(sw_oready), .out_prod(sw_prod[0]),
    .out_signed(sw_os[0])
`ifdef MBE_PERF_CNT_EN
    , .perf_txn(sw_ptxn[0]), .perf_stall(sw_pstall[0])
`endif
  );

  mbe_mult_pipe #(.WA(5), .WB(11), .LAT(8)) dut_l8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid[1]), .in_ready(sw_iready[1]),
    .in_a(sw_a[1]), .in_b(sw_b[1]), .in_signed(sw_signed[1]),
    .out_valid(sw_ov[1]), .out_ready(sw_oready), .out_prod(sw_prod[1]),
    .out_signed(sw_os[1])
`ifdef MBE_PERF_CNT_EN
    , .perf_txn(sw_ptxn[1]), .perf_stall(sw_pstall[1])
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic sg);
    logic signed [31:0] sa, sb, p;
    sa = sg ? {{24{a[7]}}, a} : {24'd0, a};
    sb = sg ? {{24{b[7]}}, b} : {24'd0, b};
    p  = sa * sb;
    return p[15:0];
  endfunction

  // Cycle counter advances on every active edge; the monitor samples on the falling edge.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (exp_q.size() == 0) begin
        checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
      end else if (out_valid) begin
        checkOutput("prod", {16'd0, out_prod}, {16'd0, exp_q[0].prod});
        checkOutput("signed", {31'd0, out_signed}, {31'd0, exp_q[0].sgn});
        if (out_ready) begin
          if (check_lat) checkOutput("latency", 32'(cyc - exp_q[0].cyc), 32'(LAT));
          void'(exp_q.pop_front());
          pops++;
        end else begin
          checkOutput("in_ready_stall", {31'd0, in_ready}, 32'd0);
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{model(in_a, in_b, in_signed), in_signed, cyc});
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the operands.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sg);
    bit taken;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sg;
    taken = 1'b0;
    n = 0;
    while (!taken && n < 100) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!taken) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) checkOutput("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic runSweep(input int idx, input logic [4:0] a, input logic [10:0] b,
                          input logic sg, input logic [15:0] expv, input int lat);
    int n;
    @(posedge clk); #1;
    sw_valid[idx] = 1'b1; sw_a[idx] = a; sw_b[idx] = b; sw_signed[idx] = sg;
    @(posedge clk); #1;
    sw_valid[idx] = 1'b0;
    n = 1;
    @(negedge clk);
    while (!sw_ov[idx] && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("sweep%0d_lat", lat), 32'(n), 32'(lat));
    checkOutput($sformatf("sweep%0d_prod", lat), {16'd0, sw_prod[idx]}, {16'd0, expv});
    checkOutput($sformatf("sweep%0d_sgn", lat), {31'd0, sw_os[idx]}, {31'd0, sg});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    sw_valid = '0; sw_a = '0; sw_b = '0; sw_signed = '0; sw_oready = 1'b1;

    repeat (2) @(posedge clk); #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_prod", {16'd0, out_prod}, 32'd0);
    checkOutput("rst_out_signed", {31'd0, out_signed}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single unsigned transfer");
    applyStimulus(8'd200, 8'd150, 1'b0);
    waitDrain();

    $display("[TB] corner operands");
    applyStimulus(8'h80, 8'h80, 1'b1);
    applyStimulus(8'h80, 8'h7f, 1'b1);
    applyStimulus(8'h00, 8'hff, 1'b1);
    applyStimulus(8'hff, 8'hff, 1'b0);
    applyStimulus(8'hff, 8'h00, 1'b0);
    waitDrain();

    $display("[TB] back-to-back random stream");
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
    waitDrain();

    $display("[TB] backpressure");
    check_lat = 1'b0;
`ifdef MBE_PERF_CNT_EN
    stall_base = perf_stall;
`endif
    fork
      for (int i = 0; i < 10; i++) applyStimulus(8'($urandom), 8'($urandom), 1'($urandom));
      begin
        repeat (4) @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();
    check_lat = 1'b1;
`ifdef MBE_PERF_CNT_EN
    checkOutput("perf_stall", perf_stall - stall_base, 32'd5);
    checkOutput("perf_txn", perf_txn, 32'(pops));
`endif

    $display("[TB] reset with transactions in flight");
    applyStimulus(8'd17, 8'd23, 1'b0);
    applyStimulus(8'hf0, 8'd9, 1'b1);
    applyStimulus(8'd99, 8'd3, 1'b0);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_prod", {16'd0, out_prod}, 32'd0);
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(8'hf3, 8'h05, 1'b1);
    waitDrain();

    $display("[TB] parameter sweep WA=5 WB=11");
    runSweep(0, 5'd31, 11'd2047, 1'b0, 16'd63457, 1);
    runSweep(1, 5'd31, 11'd2047, 1'b0, 16'd63457, 8);
    runSweep(0, 5'h10, 11'h400, 1'b1, 16'd16384, 1);
    runSweep(1, 5'h10, 11'h3ff, 1'b1, 16'hc010, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mbe_mult_pipe.md
Name: mbe_mult_pipe

Overview:
- Parametrised, pipelined radix-4 Modified Booth Encoding multiplier with valid/ready handshakes on input and output.
- Successor to the single-width, single-issue MBE test wrapper. Adds:
  - configurable operand widths and pipeline depth;
  - per-transaction signed/unsigned mode;
  - full backpressure at one result per cycle.
- Sits between the stimulus driver interface and the result monitor interface of the MBE test bench. It is also the multiplier block reused by the datapath.

Parameters:
- WA, 8, width of operand A in bits (2..32).
- WB, 8, width of operand B in bits (2..32).
- LAT, 3, pipeline depth in register stages from input accept to out_valid (1..8).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WA  multiplicand.
- in_b  in  WB  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  out_prod holds a result.
- out_ready  in  1  consumer accepts the result.
- out_prod  out  WA+WB  full-width product.
- out_signed  out  1  mode bit carried alongside the result.

Behaviour:
- Reset (rst low, asynchronous):
  - all stage valid bits clear;
  - out_valid=0, out_prod=0, out_signed=0.
  - in_ready is combinational and reads 1 immediately after reset.
- Reset asserted mid-operation discards all in-flight transactions. No partial result is ever presented.
- Handshake:
  - Transfer on the input occurs when in_valid && in_ready.
  - Transfer on the output occurs when out_valid && out_ready.
  - Inputs must not be sampled without a transfer.
  - out_prod and out_signed hold stable while out_valid && !out_ready.
- Pipeline advance enable: adv = !out_valid || out_ready.
  - in_ready = adv, purely combinational from out_valid and out_ready. No path from in_valid.
  - When adv=1, every stage (data + valid bit) shifts by one. Stage 0 loads the inputs, with valid = in_valid.
  - When adv=0, all stages hold. Bubbles are not squeezed.
- Latency: a transfer accepted at edge k produces out_valid=1 after edge k+LAT-1, with no stalls. Each stall cycle adds one.
- Throughput: one transaction per cycle while out_ready=1.
- Arithmetic:
  - Operands are extended by one bit: sign bit if in_signed=1, zero if in_signed=0. The width is then padded to even for radix-4 recoding.
  - Generates ceil((WB+2)/2) Booth partial products, each in {0, ±A, ±2A}, sign-extended. They are summed by an adder tree.
  - The tree is split across LAT stages: partial-product generation in stage 0, accumulation distributed over the remaining stages.
  - Result is exact: A*B truncated to WA+WB bits, which is lossless for both modes.
  - in_signed travels with its own data through the stages.
- Boundary cases, all exact:
  - most-negative × most-negative in signed mode;
  - all-ones × all-ones in unsigned mode;
  - any operand zero.
- Simultaneous input accept and output drain in the same cycle is permitted and is the steady-state case.
- LAT=1: single register stage; the combinational tree is entirely before it.

Optional Feature:
- Macro: MBE_PERF_CNT_EN.
- With the macro defined, two extra outputs exist:
  - perf_txn (32 bits): counts output transfers;
  - perf_stall (32 bits): counts cycles with out_valid && !out_ready.
- Both counters reset to 0 on rst low, and wrap modulo 2^32.
- Without the macro, these ports and their logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then a single unsigned transfer, WA=WB=8, LAT=3: A=200, B=150, signed=0 -> out_prod=30000 exactly 3 cycles later; out_signed=0.
- Signed corners: A=-128, B=-128 -> 16384; A=-128, B=127 -> -16256 (16'hC080); A=0, B=-1 -> 0.
- Back-to-back stream of 16 random transfers with out_ready=1 -> one result per cycle, in order, all matching a reference model.
- Backpressure: out_ready held 0 for 5 cycles mid-stream -> out_prod stable, in_ready=0; no loss or duplication after release; perf_stall=5 if MBE_PERF_CNT_EN.
- Reset pulled low while 3 transactions are in flight -> out_valid drops immediately. After release, no stale results appear, and the next input yields a correct product.
- Parameter sweep WA=5, WB=11, LAT=1 and LAT=8, both modes, unsigned A=31, B=2047 -> 63457; latency equals LAT.
